// File: rtl/bus_pkg.sv
// Shared definitions for the two-master MemoryUnit bus arbiter.
package bus_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/bus_req_latch.sv
// Per-master request register: captures one start pulse and holds it until granted.
module bus_req_latch
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clr,
  input  logic              inflight,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_we,
  output logic              pend,
  output logic              err
);

  logic accept;

  // A start is only legal when nothing from this master is queued or on the bus.
  assign accept = start && !pend && !inflight;
  assign err    = start && (pend || inflight);

  // Pending flag: set on an accepted start, cleared when the arbiter grants it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend <= 1'b1;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end

  // Request payload: only meaningful while pend is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= addr;
      req_data <= data;
      req_we   <= we;
    end
  end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master arbiter in front of the MemoryUnit start/done port.
module bus_arbiter2
  import bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_we,
  input  logic              m0_start,
  output logic [DATA_W-1:0] m0_q,
  output logic              m0_done,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_we,
  input  logic              m1_start,
  output logic [DATA_W-1:0] m1_q,
  output logic              m1_done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done,
  output logic              protocol_err
);

  state_t            state, state_nxt;
  logic              grant_vld, grant_sel;
  logic              grant_r, last_grant;
  logic              pend0, pend1, err0, err1;
  logic              clr0, clr1, inflight0, inflight1;
  logic              done_now;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_data, r1_data;
  logic              r0_we, r1_we;

  assign inflight0 = (state != IDLE) && (grant_r == M_CPU);
  assign inflight1 = (state != IDLE) && (grant_r == M_AUX);
  assign clr0      = grant_vld && (grant_sel == M_CPU);
  assign clr1      = grant_vld && (grant_sel == M_AUX);
  // bus_done only counts while a transaction is actually on the bus.
  assign done_now  = (state != IDLE) && bus_done;

  bus_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req0 (
    .clk(clk), .reset(reset), .start(m0_start), .clr(clr0), .inflight(inflight0),
    .addr(m0_addr), .data(m0_data), .we(m0_we),
    .req_addr(r0_addr), .req_data(r0_data), .req_we(r0_we), .pend(pend0), .err(err0)
  );

  bus_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req1 (
    .clk(clk), .reset(reset), .start(m1_start), .clr(clr1), .inflight(inflight1),
    .addr(m1_addr), .data(m1_data), .we(m1_we),
    .req_addr(r1_addr), .req_data(r1_data), .req_we(r1_we), .pend(pend1), .err(err1)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant decision; ties go round-robin or to master 0.
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_sel = M_CPU;
    case (state)
      IDLE: begin
        if (pend0 && pend1) begin
          grant_vld = 1'b1;
          grant_sel = (FIXED_PRIO != 0) ? M_CPU : ~last_grant;
        end else if (pend0) begin
          grant_vld = 1'b1;
          grant_sel = M_CPU;
        end else if (pend1) begin
          grant_vld = 1'b1;
          grant_sel = M_AUX;
        end
        if (grant_vld) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = bus_done ? IDLE : WAIT;
      WAIT:    if (bus_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs: start/done pulses, grant bookkeeping, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_start    <= 1'b0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      grant_r      <= M_CPU;
      last_grant   <= M_AUX;
      protocol_err <= 1'b0;
    end else begin
      bus_start <= grant_vld;
      m0_done   <= done_now && (grant_r == M_CPU);
      m1_done   <= done_now && (grant_r == M_AUX);
      if (grant_vld) begin
        grant_r    <= grant_sel;
        last_grant <= grant_sel;
      end
      if (err0 || err1) protocol_err <= 1'b1;
    end
  end

  // Data outputs: bus payload loaded at grant and held; read data to the requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_addr <= '0;
      bus_data <= '0;
      bus_we   <= 1'b0;
      m0_q     <= '0;
      m1_q     <= '0;
    end else begin
      if (grant_vld) begin
        bus_addr <= (grant_sel == M_AUX) ? r1_addr : r0_addr;
        bus_data <= (grant_sel == M_AUX) ? r1_data : r0_data;
        bus_we   <= (grant_sel == M_AUX) ? r1_we   : r0_we;
      end
      if (done_now && (grant_r == M_CPU)) m0_q <= bus_q;
      if (done_now && (grant_r == M_AUX)) m1_q <= bus_q;
    end
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: instance 0 round-robin, instance 1 fixed priority.
module tb_bus_arbiter2;

  localparam int AW = 27;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
  } req_t;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] q;
  } done_t;

  logic clk = 1'b0;
  logic rst;

  logic [AW-1:0] m0_addr [2];
  logic [DW-1:0] m0_data [2];
  logic          m0_we   [2];
  logic          m0_start[2];
  logic [DW-1:0] m0_q    [2];
  logic          m0_done [2];
  logic [AW-1:0] m1_addr [2];
  logic [DW-1:0] m1_data [2];
  logic          m1_we   [2];
  logic          m1_start[2];
  logic [DW-1:0] m1_q    [2];
  logic          m1_done [2];
  logic [AW-1:0] bus_addr [2];
  logic [DW-1:0] bus_data [2];
  logic          bus_we   [2];
  logic          bus_start[2];
  logic [DW-1:0] bus_q    [2] = '{32'h0, 32'h0};
  logic          bus_done [2] = '{1'b0, 1'b0};
  logic          protocol_err[2];

  int    mem_lat [2];
  int    n_starts[2] = '{0, 0};
  req_t  exp_req [2][$];
  done_t exp_done[2][$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == 27'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [DW-1:0] wdat(input logic [AW-1:0] a);
    return {5'h15, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int            cnt = 0;
    logic [DW-1:0] q_hold;
    req_t          e;
    done_t         ed;

    bus_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g)) dut (
      .clk(clk), .reset(rst),
      .m0_addr(m0_addr[g]), .m0_data(m0_data[g]), .m0_we(m0_we[g]), .m0_start(m0_start[g]),
      .m0_q(m0_q[g]), .m0_done(m0_done[g]),
      .m1_addr(m1_addr[g]), .m1_data(m1_data[g]), .m1_we(m1_we[g]), .m1_start(m1_start[g]),
      .m1_q(m1_q[g]), .m1_done(m1_done[g]),
      .bus_addr(bus_addr[g]), .bus_data(bus_data[g]), .bus_we(bus_we[g]),
      .bus_start(bus_start[g]), .bus_q(bus_q[g]), .bus_done(bus_done[g]),
      .protocol_err(protocol_err[g])
    );

    // MemoryUnit model: done mem_lat cycles after bus_start (0 = same cycle).
    always @(negedge clk) begin
      bus_done[g] = 1'b0;
      if (bus_start[g] && mem_lat[g] == 0) begin
        bus_done[g] = 1'b1;
        bus_q[g]    = mem_val(bus_addr[g]);
      end else if (bus_start[g]) begin
        cnt    = mem_lat[g];
        q_hold = mem_val(bus_addr[g]);
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus_done[g] = 1'b1;
          bus_q[g]    = q_hold;
        end
      end
    end

    // Scoreboard: every bus_start and every done pulse must match the next expectation.
    always @(negedge clk) begin
      if (bus_start[g]) begin
        n_starts[g]++;
        if (exp_req[g].size() == 0) begin
          check("bus_start_unexpected", 1, 0);
        end else begin
          e = exp_req[g].pop_front();
          check("bus_addr", bus_addr[g], e.a);
          check("bus_data", bus_data[g], e.d);
          check("bus_we", bus_we[g], e.we);
        end
      end
      if (m0_done[g] || m1_done[g]) begin
        if (exp_done[g].size() == 0) begin
          check("done_unexpected", {m1_done[g], m0_done[g]}, 0);
        end else begin
          ed = exp_done[g].pop_front();
          check("done_master", {m1_done[g], m0_done[g]}, ed.m ? 2'b10 : 2'b01);
          check("done_q", ed.m ? m1_q[g] : m0_q[g], ed.q);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input int d, input logic m, input logic [AW-1:0] a,
                      input logic we, input bit with_done);
    req_t  r;
    done_t x;
    r.a = a; r.d = wdat(a); r.we = we;
    exp_req[d].push_back(r);
    if (with_done) begin
      x.m = m; x.q = mem_val(a);
      exp_done[d].push_back(x);
    end
  endtask

  task automatic req(input int d, input bit s0, input logic [AW-1:0] a0,
                     input bit s1, input logic [AW-1:0] a1, input logic we1);
    if (s0) begin
      m0_start[d] = 1'b1; m0_addr[d] = a0; m0_data[d] = wdat(a0); m0_we[d] = 1'b0;
    end
    if (s1) begin
      m1_start[d] = 1'b1; m1_addr[d] = a1; m1_data[d] = wdat(a1); m1_we[d] = we1;
    end
    step();
    m0_start[d] = 1'b0;
    m1_start[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int k = 0;
    while ((exp_req[d].size() != 0 || exp_done[d].size() != 0) && k < 200) begin
      step();
      k++;
    end
    check("drain_timeout", exp_req[d].size() + exp_done[d].size(), 0);
    step();
  endtask

  task automatic check_zero(input int d, input string tag);
    check(tag, {bus_start[d], bus_we[d], m0_done[d], m1_done[d], protocol_err[d]}, 0);
    check(tag, bus_addr[d], 0);
    check(tag, bus_data[d], 0);
    check(tag, m0_q[d], 0);
    check(tag, m1_q[d], 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int s0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m0_addr[d] = '0; m0_data[d] = '0; m0_we[d] = 1'b0; m0_start[d] = 1'b0;
      m1_addr[d] = '0; m1_data[d] = '0; m1_we[d] = 1'b0; m1_start[d] = 1'b0;
      mem_lat[d] = 1;
    end
    step();
    step();
    check_zero(0, "reset_outputs0");
    check_zero(1, "reset_outputs1");
    rst = 1'b0;
    step();

    // Single read, 3-cycle slave
    mem_lat[0] = 3;
    push(0, 1'b0, 27'h100, 1'b0, 1'b1);
    req(0, 1'b1, 27'h100, 1'b0, '0, 1'b0);
    check("single_no_early_start", bus_start[0], 0);
    step();
    check("single_start_at_2", bus_start[0], 1);
    check("single_addr", bus_addr[0], 27'h100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("single_addr_held", bus_addr[0], 27'h100);
      check("single_start_one_cycle", bus_start[0], 0);
      check("single_done_early", m0_done[0], 0);
    end
    step();
    check("single_m0_done", m0_done[0], 1);
    check("single_m0_q", m0_q[0], 32'hDEADBEEF);
    check("single_m1_done", m1_done[0], 0);
    step();
    check("single_done_pulse", m0_done[0], 0);
    check("single_q_hold", m0_q[0], 32'hDEADBEEF);
    drain(0);

    // Simultaneous requests, round-robin
    do_reset();
    mem_lat[0] = 1;
    push(0, 1'b0, 27'h10, 1'b0, 1'b1);
    push(0, 1'b1, 27'h20, 1'b1, 1'b1);
    req(0, 1'b1, 27'h10, 1'b1, 27'h20, 1'b1);
    drain(0);
    push(0, 1'b0, 27'h30, 1'b0, 1'b1);
    req(0, 1'b1, 27'h30, 1'b0, '0, 1'b0);
    drain(0);
    push(0, 1'b1, 27'h50, 1'b0, 1'b1);
    push(0, 1'b0, 27'h40, 1'b0, 1'b1);
    req(0, 1'b1, 27'h40, 1'b1, 27'h50, 1'b0);
    drain(0);

    // Fixed priority: m0 wins ties; m1 served when m0 is not pending
    mem_lat[1] = 1;
    push(1, 1'b0, 27'h60, 1'b0, 1'b1);
    req(1, 1'b1, 27'h60, 1'b0, '0, 1'b0);
    drain(1);
    push(1, 1'b0, 27'h70, 1'b0, 1'b1);
    push(1, 1'b1, 27'h80, 1'b0, 1'b1);
    push(1, 1'b0, 27'h90, 1'b0, 1'b1);
    req(1, 1'b1, 27'h70, 1'b1, 27'h80, 1'b0);
    k = 0;
    while (!m0_done[1] && k < 50) begin
      step();
      k++;
    end
    check("fp_m0_done_timeout", m0_done[1], 1);
    req(1, 1'b1, 27'h90, 1'b0, '0, 1'b0);
    drain(1);
    check("fp_no_err", protocol_err[1], 0);

    // Protocol violation: second start while pending
    mem_lat[0] = 3;
    s0 = n_starts[0];
    push(0, 1'b0, 27'hA0, 1'b0, 1'b1);
    m0_start[0] = 1'b1; m0_addr[0] = 27'hA0; m0_data[0] = wdat(27'hA0); m0_we[0] = 1'b0;
    step();
    m0_addr[0] = 27'hB0; m0_data[0] = wdat(27'hB0);
    check("perr_before", protocol_err[0], 0);
    step();
    m0_start[0] = 1'b0;
    check("perr_set", protocol_err[0], 1);
    drain(0);
    repeat (3) step();
    check("perr_sticky", protocol_err[0], 1);
    check("perr_one_txn", n_starts[0] - s0, 1);

    // Zero-wait slave
    do_reset();
    check("perr_cleared", protocol_err[0], 0);
    mem_lat[0] = 0;
    push(0, 1'b0, 27'hC0, 1'b0, 1'b1);
    req(0, 1'b1, 27'hC0, 1'b0, '0, 1'b0);
    step();
    check("zw_start", bus_start[0], 1);
    check("zw_no_done_yet", m0_done[0], 0);
    step();
    check("zw_done_next", m0_done[0], 1);
    check("zw_q", m0_q[0], mem_val(27'hC0));
    check("zw_start_gone", bus_start[0], 0);
    drain(0);

    // Reset while waiting; late bus_done must be ignored
    mem_lat[0] = 4;
    push(0, 1'b0, 27'hD0, 1'b0, 1'b0);
    req(0, 1'b1, 27'hD0, 1'b0, '0, 1'b0);
    step();
    check("rw_start", bus_start[0], 1);
    step();
    do_reset();
    check_zero(0, "rw_outputs");
    for (int i = 0; i < 6; i++) begin
      step();
      check("rw_no_done", {m1_done[0], m0_done[0]}, 0);
    end
    mem_lat[0] = 1;
    push(0, 1'b0, 27'hE0, 1'b0, 1'b1);
    req(0, 1'b1, 27'hE0, 1'b0, '0, 1'b0);
    drain(0);
    check("rw_after_q", m0_q[0], mem_val(27'hE0));

    check("queues_empty", exp_req[0].size() + exp_req[1].size()
                          + exp_done[0].size() + exp_done[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-master arbiter directly upstream of the MemoryUnit bus port.
- Lets a second bus master (DMA or GPU-side copy engine) share the MemoryUnit with the CPU using the existing start/done pulse handshake.
- Captures each master's single-cycle request, grants one transaction at a time to the MemoryUnit, and routes the done pulse and read data back to the requester only.
- The CPU connects to master 0 unchanged.

Parameters:
- ADDR_W, 27, bus address width
- DATA_W, 32, bus data width
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties

Ports:
- clk  in  1  system clock; sole clock
- reset  in  1  synchronous, active-high reset
- m0_addr  in  ADDR_W  master 0 (CPU) address
- m0_data  in  DATA_W  master 0 write data
- m0_we  in  1  master 0 write enable
- m0_start  in  1  master 0 request pulse
- m0_q  out  DATA_W  master 0 read data
- m0_done  out  1  master 0 completion pulse
- m1_addr, m1_data, m1_we, m1_start, m1_q, m1_done  same as m0_*, for master 1
- bus_addr  out  ADDR_W  to MemoryUnit
- bus_data  out  DATA_W  to MemoryUnit
- bus_we  out  1  to MemoryUnit
- bus_start  out  1  one-cycle request pulse to MemoryUnit
- bus_q  in  DATA_W  MemoryUnit read data, valid with bus_done
- bus_done  in  1  MemoryUnit completion pulse
- protocol_err  out  1  sticky flag; set when a master violates the handshake

Behaviour:
- Reset values: all outputs 0, state IDLE, both pending bits 0, last_grant = 1 (so master 0 wins the first tie), protocol_err 0.
- Capture:
  - mX_start = 1 while pendX = 0 and master X is not in flight: latch addr/data/we into the master X request register and set pendX at the clock edge.
  - mX_start while pendX = 1 or master X is in flight: request dropped, protocol_err set.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - No pending request: stay in IDLE.
  - One pending: grant it.
  - Both pending, FIXED_PRIO = 0: grant the master != last_grant.
  - Both pending, FIXED_PRIO = 1: grant master 0.
  - On grant: load bus_addr/bus_data/bus_we from the granted request register, clear that master's pend bit, set last_grant, go to ISSUE.
- ISSUE:
  - bus_start = 1 for exactly this cycle.
  - bus_done in this cycle counts as completion; otherwise go to WAIT.
- WAIT: hold bus_addr/bus_data/bus_we stable until bus_done = 1.
- Completion:
  - Register bus_q into mG_q and pulse mG_done = 1 for one cycle (the cycle after bus_done); return to IDLE in that same cycle.
  - mG_q holds its value until the next completion to that master.
  - The other master's done never pulses.
- bus_done while in IDLE: ignored.
- Latency, uncontended, with m0_start in cycle 0:
  - Cycle 1: pend visible, IDLE grants.
  - Cycle 2: bus_start.
  - MemoryUnit done in cycle N gives m0_done in cycle N+1.
  - Arbitration overhead is 2 cycles before bus_start, 1 cycle after bus_done.
- Back-to-back operation:
  - A request captured while another is in flight is served starting from the IDLE cycle after completion.
  - A master may issue its next start in the same cycle its done is seen.
- Reset mid-transaction:
  - Abandons the transaction: no done pulse, pend bits cleared, outputs zeroed.
  - A late bus_done after reset is ignored because the FSM is in IDLE.
- Throughput under contention (round-robin): strict alternation, no master waits more than one transaction.

Decomposition:
- Shared package bus_pkg:
  - ADDR_W / DATA_W defaults
  - state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2)
  - master index constants M_CPU = 0, M_AUX = 1
- Sub-module bus_req_latch, instantiated once per master:
  - holds addr/data/we and the pend bit
  - inputs: start, clr, inflight
  - outputs: the latched request, pend, err pulse
- Top holds the FSM, grant logic, and output mux/registers.

Test Plan:
- Single read: m0_start with m0_addr = 27'h000100; MemoryUnit model returns 32'hDEADBEEF with bus_done 3 cycles after bus_start -> bus_start exactly 2 cycles after m0_start, bus_addr = 0x100 held through done, m0_q = DEADBEEF with a one-cycle m0_done, m1_done stays 0.
- Simultaneous requests, FIXED_PRIO = 0: m0_start and m1_start in the same cycle (addr 0x10 / 0x20) -> m0 served first, then m1; bus_addr sequence 0x10, 0x20; the next simultaneous pair is served m1 first.
- FIXED_PRIO = 1: m1 pending with m0 reissuing continuously -> m0 wins every tie; m1 is served only in an IDLE cycle with m0 not pending.
- Protocol violation: m0_start pulsed twice before m0_done -> second request dropped, protocol_err = 1 and sticky, exactly one bus transaction issued.
- Zero-wait slave: bus_done asserted in the same cycle as bus_start -> completion accepted from ISSUE, m0_done the next cycle, no WAIT state entered.
- Reset in WAIT: reset asserted 1 cycle after bus_start, bus_done arrives after reset releases -> no mX_done, all outputs 0, state IDLE, and a new request afterwards completes normally.
